// File: rtl/vga_scanout_if.sv
// Pixel stream between the renderer and the scanout stage: 12-bit {r,g,b} words
// with a start-of-frame marker, transferred on valid && ready.
interface vga_scanout_if;
    logic        pix_valid;
    logic        pix_ready;
    logic [11:0] pix_data;
    logic        pix_sof;

    modport master (output pix_valid, output pix_data, output pix_sof, input pix_ready);
    modport slave  (input pix_valid, input pix_data, input pix_sof, output pix_ready);
endinterface

// File: rtl/vga_scanout.sv
// Final video stage: raster timing, elastic pixel FIFO and frame-alignment FSM
// producing the registered {hsync, vsync, rgb} vgaData bus.
module vga_scanout #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter bit          SYNC_POL   = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    vga_scanout_if.slave        pix,
    output logic [13:0]         vgaData,
    output logic [9:0]          hcount,
    output logic [9:0]          vcount,
    output logic                frame_start,
    output logic [15:0]         underflow_cnt
);
    localparam int unsigned CW       = 10;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam int unsigned PW       = AW + 1;
    localparam int unsigned EW       = 13;

    typedef enum logic {ALIGN, STREAM} state_t;

    state_t          state;
    logic [EW-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            fifo_empty;
    logic            fifo_full;
    logic            push;
    logic            head_sof;
    logic [11:0]     head_data;

    logic [CW-1:0]   nx;
    logic [CW-1:0]   ny;
    logic            slot_active;
    logic            slot_origin;
    logic            hs_lvl;
    logic            vs_lvl;

    // FIFO flags; ready ignores a same-cycle pop and is held low in reset
    assign fifo_empty    = (wr_ptr == rd_ptr);
    assign fifo_full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pix.pix_ready = !fifo_full && !reset;
    assign push          = pix.pix_valid && pix.pix_ready;
    assign head_sof      = mem[rd_ptr[AW-1:0]][12];
    assign head_data     = mem[rd_ptr[AW-1:0]][11:0];

    // Geometry of the slot that the coming edge puts on vgaData
    always_comb begin
        nx = hcount + CW'(1);
        ny = vcount;
        if (hcount == CW'(H_TOTAL - 1)) begin
            nx = '0;
            ny = (vcount == CW'(V_TOTAL - 1)) ? '0 : vcount + CW'(1);
        end
        slot_active = (nx < CW'(H_ACTIVE)) && (ny < CW'(V_ACTIVE));
        slot_origin = (nx == '0) && (ny == '0);
        hs_lvl = ((nx >= CW'(HS_START)) && (nx < CW'(HS_END))) ? SYNC_POL : !SYNC_POL;
        vs_lvl = ((ny >= CW'(VS_START)) && (ny < CW'(VS_END))) ? SYNC_POL : !SYNC_POL;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {pix.pix_sof, pix.pix_data};
        end
    end

    // Raster counters, alignment FSM, FIFO pointers and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ALIGN;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            hcount        <= CW'(H_TOTAL - 1);
            vcount        <= CW'(V_TOTAL - 1);
            frame_start   <= 1'b0;
            underflow_cnt <= '0;
            vgaData       <= {!SYNC_POL, !SYNC_POL, 12'h000};
        end else begin
            hcount      <= nx;
            vcount      <= ny;
            frame_start <= slot_origin;
            vgaData     <= {hs_lvl, vs_lvl, 12'h000};
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            case (state)
                ALIGN: begin
                    if (!fifo_empty) begin
                        if (!head_sof) begin
                            rd_ptr <= rd_ptr + PW'(1);
                        end else if (slot_origin) begin
                            rd_ptr  <= rd_ptr + PW'(1);
                            vgaData <= {hs_lvl, vs_lvl, head_data};
                            state   <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (slot_active) begin
                        if (fifo_empty) begin
                            if (underflow_cnt != 16'hFFFF) begin
                                underflow_cnt <= underflow_cnt + 16'd1;
                            end
                        end else if (head_sof == slot_origin) begin
                            rd_ptr  <= rd_ptr + PW'(1);
                            vgaData <= {hs_lvl, vs_lvl, head_data};
                        end else begin
                            // sof arrived early or frame start has no sof: resync
                            state <= ALIGN;
                        end
                    end
                end
                default: state <= ALIGN;
            endcase
        end
    end
endmodule
